// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable clock divider with a glitch-free divide-value update path.
// slow_clock toggles every active_div enabled cycles of main_clock; tick
// pulses for one cycle together with each toggle. A new divide value is
// offered through a valid/ready handshake. While stopped it is applied at
// once. While running it is held in a shadow register and applied only at
// the next terminal count, so a half-period is never cut short.
//
// State table
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_DISABLED | counter and slow_clock frozen; new values apply at once
//   ST_RUN      | counting; a handshake loads the shadow register
//   ST_PENDING  | counting; shadow value waits for the next terminal count
//
// Ports
//   main_clock  in   single clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   counting enable
//   cfg_valid   in   a new divide value is offered
//   cfg_div     in   offered half-period divide value (0 is rejected)
//   cfg_ready   out  a new value can be accepted this cycle
//   slow_clock  out  divided clock
//   tick        out  one-cycle pulse on every slow_clock toggle
//   active_div  out  divide value currently in use
//   pending     out  an accepted value waits to be applied
//   cfg_err     out  one-cycle pulse after a zero value was offered
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = 24
) (
    input  logic             main_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             slow_clock,
    output logic             tick,
    output logic [WIDTH-1:0] active_div,
    output logic             pending,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_PENDING  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] div_q,    div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             slow_q,   slow_d;
    logic             tick_q,   tick_d;
    logic             err_q,    err_d;
    logic             ready_q,  ready_d;
    logic             pend_q,   pend_d;

    logic             hs;
    logic             hs_ok;
    logic             tc;

    // div_q is never zero (zero values are rejected), so div_q - 1 cannot
    // underflow and the counter never needs to wrap.
    assign tc    = (cnt_q == (div_q - ONE));
    assign hs    = cfg_valid && ready_q;
    assign hs_ok = hs && (cfg_div != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        slow_d   = slow_q;
        tick_d   = 1'b0;
        err_d    = hs && (cfg_div == '0);

        case (state_q)
            ST_DISABLED: begin
                // A new value takes priority over leaving the stopped state,
                // so it is visible before the first counted cycle.
                if (hs_ok) begin
                    div_d = cfg_div;
                    cnt_d = '0;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (enable) begin
                    if (tc) begin
                        cnt_d  = '0;
                        slow_d = ~slow_q;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                // A value accepted on a terminal-count cycle only goes to the
                // shadow register, so it waits for the following terminal count.
                if (hs_ok) begin
                    shadow_d = cfg_div;
                    state_d  = ST_PENDING;
                end else if (!enable) begin
                    state_d = ST_DISABLED;
                end
            end

            ST_PENDING: begin
                if (enable) begin
                    if (tc) begin
                        div_d   = shadow_q;
                        cnt_d   = '0;
                        slow_d  = ~slow_q;
                        tick_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    // Stopping: nothing is in flight, so apply immediately
                    // and keep slow_clock at its current level.
                    div_d   = shadow_q;
                    cnt_d   = '0;
                    state_d = ST_DISABLED;
                end
            end

            default: begin
                state_d = ST_DISABLED;
            end
        endcase
    end

    // Handshake status is registered from the next state so that cfg_ready
    // and pending are valid in the same cycle the state they describe is.
    assign ready_d = (state_d != ST_PENDING);
    assign pend_d  = (state_d == ST_PENDING);

    always_ff @(posedge main_clock) begin
        if (reset) begin
            state_q  <= ST_DISABLED;
            cnt_q    <= '0;
            div_q    <= DIV_INIT;
            shadow_q <= '0;
            slow_q   <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            slow_q   <= slow_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            pend_q   <= pend_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign slow_clock = slow_q;
    assign tick       = tick_q;
    assign active_div = div_q;
    assign pending    = pend_q;
    assign cfg_err    = err_q;

endmodule
